// File: rtl/gelato_simt_stack_table.sv
//==============================================================================
// Module      : gelato_simt_stack_table
// Description : Per-warp SIMT reconvergence stack. Each warp keeps a stack of
//               {pc, reconvergence pc, thread mask} entries. The stacks are
//               driven by branch/join outcomes from decode and feed the fetch
//               scheduler with per-warp PC, mask and fetchable flags.
//               Optional macro GELATO_SIMT_STACK_PERF_EN adds peak_depth, the
//               per-warp high-water mark of stack depth.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gelato_simt_stack_table #(
    parameter int WARP_NUM    = 4,
    parameter int THREAD_NUM  = 32,
    parameter int STACK_DEPTH = 8,
    parameter int PC_WIDTH    = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       rdy,
    input  logic                                       init_valid,
    input  logic [PC_WIDTH-1:0]                        init_pc,
    input  logic [$clog2(WARP_NUM*THREAD_NUM+1)-1:0]   init_threads,
    input  logic                                       op_valid,
    input  logic [$clog2(WARP_NUM)-1:0]                op_warp,
    input  logic [1:0]                                 op_kind,
    input  logic                                       op_stall,
    input  logic [PC_WIDTH-1:0]                        op_next_pc,
    input  logic [PC_WIDTH-1:0]                        op_taken_pc,
    input  logic [THREAD_NUM-1:0]                      op_taken_mask,
    input  logic [PC_WIDTH-1:0]                        op_rpc,
    output logic [WARP_NUM-1:0]                        sel_valid,
    output logic [WARP_NUM*PC_WIDTH-1:0]               sel_pc,
    output logic [WARP_NUM*THREAD_NUM-1:0]             sel_mask,
    output logic [THREAD_NUM-1:0]                      op_mask,
    output logic                                       activate_valid,
    output logic [$clog2(WARP_NUM)-1:0]                activate_warp,
`ifdef GELATO_SIMT_STACK_PERF_EN
    output logic [WARP_NUM*$clog2(STACK_DEPTH+1)-1:0]  peak_depth,
`endif
    output logic [WARP_NUM-1:0]                        overflow
);

    localparam int WW  = $clog2(WARP_NUM);
    localparam int DW  = $clog2(STACK_DEPTH+1);
    localparam int DW1 = DW + 1;
    localparam int IW  = $clog2(STACK_DEPTH);
    localparam int TW  = $clog2(WARP_NUM*THREAD_NUM+1);

    localparam logic [1:0] c_ADVANCE = 2'd0;
    localparam logic [1:0] c_SPLIT   = 2'd1;
    localparam logic [1:0] c_JOIN    = 2'd2;
    localparam logic [1:0] c_EXIT    = 2'd3;

    logic [PC_WIDTH-1:0]   r_pc   [WARP_NUM][STACK_DEPTH];
    logic [PC_WIDTH-1:0]   r_rpc  [WARP_NUM][STACK_DEPTH];
    logic [THREAD_NUM-1:0] r_mask [WARP_NUM][STACK_DEPTH];
    logic [DW-1:0]         r_depth[WARP_NUM];
    logic [WARP_NUM-1:0]   r_held;
    logic [WARP_NUM-1:0]   r_overflow;
    logic                  r_act_valid;
    logic [WW-1:0]         r_act_warp;
`ifdef GELATO_SIMT_STACK_PERF_EN
    logic [DW-1:0]         r_peak [WARP_NUM];
`endif

    // Decode-side view of the addressed warp's top of stack
    logic [DW-1:0]         w_depth;
    logic                  w_has;
    logic [IW-1:0]         w_top;
    logic [IW-1:0]         w_top1;
    logic [IW-1:0]         w_top2;
    logic [THREAD_NUM-1:0] w_m;
    logic [THREAD_NUM-1:0] w_t;
    logic                  w_room;
    logic                  w_accept;

    assign w_depth  = r_depth[op_warp];
    assign w_has    = (w_depth != '0);
    assign w_top    = IW'(w_depth - DW'(1));
    assign w_top1   = w_top + IW'(1);
    assign w_top2   = w_top + IW'(2);
    assign w_m      = w_has ? r_mask[op_warp][w_top] : '0;
    assign w_t      = op_taken_mask & w_m;
    assign w_room   = ({1'b0, w_depth} + DW1'(2)) <= DW1'(STACK_DEPTH);
    // A JOIN on an empty stack is dropped entirely; overflowed warps wait for init
    assign w_accept = op_valid && !r_overflow[op_warp] && !(op_kind == c_JOIN && !w_has);
    assign op_mask  = w_m;

    // Launch masks: full warps, then one partial warp, then empty warps
    logic [TW-1:0]         w_f;
    logic [TW-1:0]         w_r;
    logic [THREAD_NUM-1:0] w_part;
    logic [THREAD_NUM-1:0] w_init_mask [WARP_NUM];

    assign w_f    = init_threads / TW'(THREAD_NUM);
    assign w_r    = init_threads % TW'(THREAD_NUM);
    assign w_part = (THREAD_NUM'(1) << w_r) - THREAD_NUM'(1);

    // Per-warp launch mask from the total thread count
    always_comb begin
        for (int w = 0; w < WARP_NUM; w++) begin
            w_init_mask[w] = '0;
            if (TW'(w) < w_f)
                w_init_mask[w] = '1;
            else if (TW'(w) == w_f)
                w_init_mask[w] = w_part;
        end
    end

    // Stack state, hold flags and activation handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WARP_NUM; w++) begin
                r_depth[w] <= '0;
`ifdef GELATO_SIMT_STACK_PERF_EN
                r_peak[w]  <= '0;
`endif
                for (int d = 0; d < STACK_DEPTH; d++) begin
                    r_pc[w][d]   <= '0;
                    r_rpc[w][d]  <= '0;
                    r_mask[w][d] <= '0;
                end
            end
            r_held      <= '0;
            r_overflow  <= '0;
            r_act_valid <= 1'b0;
            r_act_warp  <= '0;
        end else if (rdy) begin
            r_act_valid <= 1'b0;
            if (init_valid) begin
                for (int w = 0; w < WARP_NUM; w++) begin
                    r_depth[w]   <= (w_init_mask[w] != '0) ? DW'(1) : '0;
`ifdef GELATO_SIMT_STACK_PERF_EN
                    r_peak[w]    <= (w_init_mask[w] != '0) ? DW'(1) : '0;
`endif
                    r_pc[w][0]   <= init_pc;
                    r_rpc[w][0]  <= '0;
                    r_mask[w][0] <= w_init_mask[w];
                end
                r_held     <= '0;
                r_overflow <= '0;
            end else if (w_accept) begin
                r_held[op_warp] <= op_stall;
                r_act_valid     <= !op_stall;
                r_act_warp      <= op_warp;
                if (w_has) begin
                    case (op_kind)
                        c_ADVANCE: r_pc[op_warp][w_top] <= op_next_pc;
                        c_SPLIT: begin
                            if (w_t == '0) begin
                                r_pc[op_warp][w_top] <= op_next_pc;
                            end else if (w_t == w_m) begin
                                r_pc[op_warp][w_top] <= op_taken_pc;
                            end else if (w_room) begin
                                // Current entry becomes the reconvergence point;
                                // not-taken is pushed below taken so taken runs first
                                r_pc[op_warp][w_top]    <= op_rpc;
                                r_pc[op_warp][w_top1]   <= op_next_pc;
                                r_rpc[op_warp][w_top1]  <= op_rpc;
                                r_mask[op_warp][w_top1] <= w_m & ~w_t;
                                r_pc[op_warp][w_top2]   <= op_taken_pc;
                                r_rpc[op_warp][w_top2]  <= op_rpc;
                                r_mask[op_warp][w_top2] <= w_t;
                                r_depth[op_warp]        <= w_depth + DW'(2);
`ifdef GELATO_SIMT_STACK_PERF_EN
                                if ((w_depth + DW'(2)) > r_peak[op_warp])
                                    r_peak[op_warp] <= w_depth + DW'(2);
`endif
                            end else begin
                                r_overflow[op_warp] <= 1'b1;
                            end
                        end
                        c_JOIN:  r_depth[op_warp] <= w_depth - DW'(1);
                        c_EXIT:  r_depth[op_warp] <= '0;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign activate_valid = r_act_valid;
    assign activate_warp  = r_act_warp;
    assign overflow       = r_overflow;

    // Per-warp fetch view of the top of stack
    for (genvar g = 0; g < WARP_NUM; g++) begin : g_warp
        logic [IW-1:0] w_idx;
        logic          w_nz;
        assign w_nz  = (r_depth[g] != '0);
        assign w_idx = w_nz ? IW'(r_depth[g] - DW'(1)) : '0;
        assign sel_valid[g] = w_nz && !r_held[g] && !r_overflow[g];
        assign sel_pc[g*PC_WIDTH +: PC_WIDTH]       = r_pc[g][w_idx];
        assign sel_mask[g*THREAD_NUM +: THREAD_NUM] = w_nz ? r_mask[g][w_idx] : '0;
`ifdef GELATO_SIMT_STACK_PERF_EN
        assign peak_depth[g*DW +: DW] = r_peak[g];
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_gelato_simt_stack_table.sv
`default_nettype none

module tb_gelato_simt_stack_table;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rdy = 1'b1;
    logic         init_valid = 1'b0;
    logic [31:0]  init_pc = '0;
    logic [7:0]   init_threads = '0;
    logic         op_valid = 1'b0;
    logic [1:0]   op_warp = '0;
    logic [1:0]   op_kind = '0;
    logic         op_stall = 1'b0;
    logic [31:0]  op_next_pc = '0;
    logic [31:0]  op_taken_pc = '0;
    logic [31:0]  op_taken_mask = '0;
    logic [31:0]  op_rpc = '0;
    logic [3:0]   sel_valid;
    logic [127:0] sel_pc;
    logic [127:0] sel_mask;
    logic [31:0]  op_mask;
    logic         activate_valid;
    logic [1:0]   activate_warp;
    logic [3:0]   overflow;
`ifdef GELATO_SIMT_STACK_PERF_EN
    logic [15:0]  peak_depth;
`endif

    int total = 0;
    int bad   = 0;

    gelato_simt_stack_table #(
        .WARP_NUM(4), .THREAD_NUM(32), .STACK_DEPTH(8), .PC_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .init_valid(init_valid), .init_pc(init_pc), .init_threads(init_threads),
        .op_valid(op_valid), .op_warp(op_warp), .op_kind(op_kind), .op_stall(op_stall),
        .op_next_pc(op_next_pc), .op_taken_pc(op_taken_pc),
        .op_taken_mask(op_taken_mask), .op_rpc(op_rpc),
        .sel_valid(sel_valid), .sel_pc(sel_pc), .sel_mask(sel_mask), .op_mask(op_mask),
        .activate_valid(activate_valid), .activate_warp(activate_warp),
`ifdef GELATO_SIMT_STACK_PERF_EN
        .peak_depth(peak_depth),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] w, input logic [1:0] k, input logic st,
                      input logic [31:0] npc, input logic [31:0] tpc,
                      input logic [31:0] tm, input logic [31:0] rpc);
        op_valid = 1'b1; op_warp = w; op_kind = k; op_stall = st;
        op_next_pc = npc; op_taken_pc = tpc; op_taken_mask = tm; op_rpc = rpc;
        tick();
        op_valid = 1'b0;
    endtask

    function automatic logic [31:0] pcw(input int w);
        return sel_pc[w*32 +: 32];
    endfunction

    function automatic logic [31:0] mkw(input int w);
        return sel_mask[w*32 +: 32];
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_sel_valid", 128'(sel_valid), 128'h0);
        chk("rst_sel_pc", sel_pc, 128'h0);
        chk("rst_sel_mask", sel_mask, 128'h0);
        chk("rst_act", {126'h0, activate_valid, 1'b0} | 128'(activate_warp), 128'h0);
        chk("rst_overflow", 128'(overflow), 128'h0);
        rst_n = 1'b1;
        tick();

        // Launch 70 threads: two full warps, 6 threads in warp2, warp3 empty
        init_valid = 1'b1; init_pc = 32'h100; init_threads = 8'd70;
        tick();
        init_valid = 1'b0;
        chk("init_sel_valid", 128'(sel_valid), 128'h7);
        chk("init_sel_mask", sel_mask, 128'h00000000_0000003F_FFFFFFFF_FFFFFFFF);
        chk("init_sel_pc", sel_pc, 128'h00000100_00000100_00000100_00000100);
        op_warp = 2'd2;
        #1;
        chk("op_mask_w2", 128'(op_mask), 128'h3F);

        // Partial split on warp0, then two joins back to reconvergence
        op(2'd0, 2'd1, 1'b0, 32'h104, 32'h200, 32'h0000FFFF, 32'h300);
        chk("split_pc", 128'(pcw(0)), 128'h200);
        chk("split_mask", 128'(mkw(0)), 128'h0000FFFF);
        chk("split_act", {126'h0, activate_valid, activate_warp == 2'd0}, 128'h3);
        op(2'd0, 2'd2, 1'b0, 0, 0, 0, 0);
        chk("join1_pc", 128'(pcw(0)), 128'h104);
        chk("join1_mask", 128'(mkw(0)), 128'hFFFF0000);
        op(2'd0, 2'd2, 1'b0, 0, 0, 0, 0);
        chk("join2_pcmask", {64'h0, pcw(0), mkw(0)}, {64'h0, 32'h300, 32'hFFFFFFFF});

        // Uniform splits do not push
        op(2'd0, 2'd1, 1'b0, 32'h304, 32'h400, 32'hFFFFFFFF, 32'h999);
        chk("split_all_pc", 128'(pcw(0)), 128'h400);
        op(2'd0, 2'd1, 1'b0, 32'h500, 32'h600, 32'h0, 32'h999);
        chk("split_none_pc", 128'(pcw(0)), 128'h500);
        op(2'd0, 2'd2, 1'b0, 0, 0, 0, 0);
        chk("depth1_join_done", 128'(sel_valid), 128'h6);

        // Relaunch, then nest three partial splits to depth 7; the fourth overflows
        init_valid = 1'b1; init_pc = 32'h100; init_threads = 8'd70;
        tick();
        init_valid = 1'b0;
        op(2'd0, 2'd1, 1'b0, 32'h110, 32'h210, 32'h0000FFFF, 32'h310);
        op(2'd0, 2'd1, 1'b0, 32'h120, 32'h220, 32'h000000FF, 32'h320);
        op(2'd0, 2'd1, 1'b0, 32'h130, 32'h230, 32'h0000000F, 32'h330);
        chk("depth7_tos", {64'h0, pcw(0), mkw(0)}, {64'h0, 32'h230, 32'h0000000F});
        chk("depth7_no_ovf", 128'(overflow), 128'h0);
        op(2'd0, 2'd1, 1'b0, 32'h140, 32'h240, 32'h00000003, 32'h340);
        chk("ovf_flag", 128'(overflow), 128'h1);
        chk("ovf_sel_valid", 128'(sel_valid), 128'h6);
        chk("ovf_tos_kept", 128'(pcw(0)), 128'h230);

        // Stall holds warp1; a following unstalled op releases it
        op(2'd1, 2'd0, 1'b1, 32'h108, 0, 0, 0);
        chk("stall_sel_valid", 128'(sel_valid), 128'h4);
        chk("stall_act_valid", 128'(activate_valid), 128'h0);
        op(2'd1, 2'd0, 1'b0, 32'h10C, 0, 0, 0);
        chk("unstall_sel_valid", 128'(sel_valid), 128'h6);
        chk("unstall_act", {126'h0, activate_valid, 1'b0} | 128'(activate_warp), 128'h3);
        chk("unstall_pc", 128'(pcw(1)), 128'h10C);

        // rdy low freezes everything
        rdy = 1'b0;
        op(2'd1, 2'd3, 1'b0, 32'h999, 0, 0, 0);
        chk("frozen_pc", 128'(pcw(1)), 128'h10C);
        chk("frozen_valid_act", {124'h0, sel_valid} | {127'h0, activate_valid} << 4, 128'h16);
        rdy = 1'b1;

        // Init wins over a same-cycle op
        init_valid = 1'b1; init_pc = 32'h700; init_threads = 8'd64;
        op(2'd2, 2'd0, 1'b0, 32'h888, 0, 0, 0);
        init_valid = 1'b0;
        chk("init_win_valid", 128'(sel_valid), 128'h3);
        chk("init_win_ovf", 128'(overflow), 128'h0);
        chk("init_win_pc", sel_pc, 128'h00000700_00000700_00000700_00000700);
        chk("init_win_act", 128'(activate_valid), 128'h0);

        // JOIN on an empty warp is ignored, no activation
        op(2'd3, 2'd2, 1'b0, 0, 0, 0, 0);
        chk("join_empty_act", 128'(activate_valid), 128'h0);
        // EXIT empties warp1 and activates it
        op(2'd1, 2'd3, 1'b0, 0, 0, 0, 0);
        chk("exit_valid", 128'(sel_valid), 128'h1);
        chk("exit_act", {126'h0, activate_valid, 1'b0} | 128'(activate_warp), 128'h3);

        // Asynchronous reset in the middle of a nested stack
        op(2'd0, 2'd1, 1'b0, 32'h704, 32'h800, 32'h00FF00FF, 32'h900);
        chk("pre_rst_pc", 128'(pcw(0)), 128'h800);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(sel_valid), 128'h0);
        chk("async_rst_pc", sel_pc, 128'h0);
        chk("async_rst_mask", sel_mask, 128'h0);
        chk("async_rst_act", {126'h0, activate_valid, 1'b0} | 128'(activate_warp), 128'h0);
        chk("async_rst_ovf", 128'(overflow), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/gelato_simt_stack_table.md
Name: gelato_simt_stack_table

Overview:
- Parametrised successor to the single-level split table: a per-warp SIMT reconvergence stack.
- Holds {pc, reconvergence pc, thread mask} entries per warp and supports nested divergence up to STACK_DEPTH.
- Sits between instruction decode (branch/join outcomes) and the fetch scheduler (per-warp PC/mask/valid).
- Supports warp launch from a total thread count.

Parameters:
WARP_NUM, 4, number of warps (power of 2, ≥2)
THREAD_NUM, 32, threads per warp (mask width)
STACK_DEPTH, 8, entries per warp stack (≥3)
PC_WIDTH, 32, PC width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; low freezes all state
init_valid  in  1  launch kernel
init_pc  in  PC_WIDTH  kernel entry PC
init_threads  in  clog2(WARP_NUM*THREAD_NUM+1)  total threads to launch
op_valid  in  1  decode outcome valid
op_warp  in  clog2(WARP_NUM)  target warp
op_kind  in  2  0=ADVANCE 1=SPLIT 2=JOIN 3=EXIT
op_stall  in  1  hold warp after this op
op_next_pc  in  PC_WIDTH  fall-through PC
op_taken_pc  in  PC_WIDTH  branch target
op_taken_mask  in  THREAD_NUM  threads taking branch
op_rpc  in  PC_WIDTH  reconvergence PC (SPLIT only)
sel_valid  out  WARP_NUM  warp fetchable
sel_pc  out  WARP_NUM*PC_WIDTH  TOS pc per warp, warp w at [w*PC_WIDTH +: PC_WIDTH]
sel_mask  out  WARP_NUM*THREAD_NUM  TOS mask per warp
op_mask  out  THREAD_NUM  combinational TOS mask of op_warp
activate_valid  out  1  registered: op accepted with op_stall=0
activate_warp  out  clog2(WARP_NUM)  warp of activate_valid
overflow  out  WARP_NUM  sticky per-warp stack overflow

Behaviour:
- Reset: all depth=0, held=0, sel_valid=0, sel_pc=0, sel_mask=0, activate_valid=0, activate_warp=0, overflow=0.
- All updates on posedge clk gated by rdy; outputs are registered state (1-cycle latency), except op_mask.
- sel_valid[w] = depth[w]!=0 && !held[w] && !overflow[w].
- Init (init_valid, rdy):
  - F = init_threads / THREAD_NUM, R = init_threads % THREAD_NUM.
  - Warp w<F: mask all ones. w==F: mask (1<<R)-1. Else mask 0.
  - Warps with nonzero mask: depth=1, TOS={init_pc, rpc=0, mask}. Others depth=0.
  - Clears held and overflow. Init wins over same-cycle op; that op is dropped.
- Op (op_valid, rdy, no init), let M=TOS mask, T=op_taken_mask&M:
  - ADVANCE: TOS.pc<=op_next_pc.
  - SPLIT with T==0: TOS.pc<=op_next_pc.
  - SPLIT with T==M: TOS.pc<=op_taken_pc.
  - SPLIT otherwise: needs depth+2≤STACK_DEPTH.
    - TOS becomes {op_rpc, M}.
    - Push {op_next_pc, rpc=op_rpc, M&~T}, then push {op_taken_pc, rpc=op_rpc, T}; depth+=2.
    - Taken path executes first.
    - Insufficient room: overflow[w]<=1, state unchanged.
  - JOIN: pop (depth-=1). Depth 1→0 allowed (warp done). JOIN at depth 0 ignored.
  - EXIT: depth<=0.
  - held[w]<=op_stall.
  - activate_valid<=!op_stall; activate_warp<=op_warp. Otherwise activate_valid<=0.
  - Op to a warp with depth 0 (except the ignored JOIN) still updates held and activate, and has no stack effect.
- One op per cycle; no backpressure. Ops to overflowed warps are ignored until the next init.
- Reset mid-operation discards all stacks immediately (async).

Optional Feature:
- Macro GELATO_SIMT_STACK_PERF_EN.
- Defined: adds output peak_depth (WARP_NUM*clog2(STACK_DEPTH+1)), the per-warp high-water mark of depth. It is cleared by reset and by init (set to 1 for launched warps), and updates the same cycle depth rises.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Init init_threads=70, THREAD_NUM=32, WARP_NUM=4, init_pc=0x100 -> next cycle sel_valid=0b0111; masks FFFFFFFF, FFFFFFFF, 0000003F; warp3 mask 0; all pc 0x100.
- Warp0 SPLIT taken_mask=0x0000FFFF, taken_pc=0x200, next_pc=0x104, rpc=0x300 -> TOS {0x200, 0x0000FFFF}. JOIN -> {0x104, 0xFFFF0000}. JOIN -> {0x300, FFFFFFFF}, depth 1.
- SPLIT with taken_mask=0xFFFFFFFF on full warp -> pc=taken_pc, depth unchanged. taken_mask=0 -> pc=next_pc.
- STACK_DEPTH=8: three partial SPLITs (depth 7), fourth partial SPLIT -> overflow[w]=1, sel_valid[w]=0; init clears it.
- op_stall=1 on warp1 -> sel_valid[1]=0, activate_valid=0. Next op with stall=0 -> sel_valid[1]=1, activate_valid=1, activate_warp=1.
- rdy=0 with op_valid=1 -> no state change. Same-cycle init and op -> init result only. Assert rst_n low mid-stack -> all outputs 0 asynchronously.
